// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
//   state_t : FSM state encoding (IDLE / SHIFT / DONE)
//   clog2   : constant ceil(log2(v)), never less than 1, used to size the bit counter
package serial_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Width needed to count 0..v-1; a 1-bit floor keeps the counter declarable.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// 1-bit full subtractor built from two cascaded half-subtractor stages.
//   a      : minuend bit
//   b      : subtrahend bit
//   bin    : borrow in
//   d_c    : difference bit a - b - bin (combinational)
//   bout_c : borrow out (combinational)
module serial_sub_ctrl_fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d_c,
  output logic bout_c
);

  logic d1;
  logic br1;
  logic br2;

  // First stage: a - b.
  assign d1  = a ^ b;
  assign br1 = ~a & b;

  // Second stage: (a - b) - bin.
  assign d_c    = d1 ^ bin;
  assign br2    = ~d1 & bin;
  assign bout_c = br1 | br2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell is reused for every
// operand bit, LSB first, with the borrow held in a register between bits.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : request, accepted only in IDLE or DONE
//   a_in, b_in : minuend / subtrahend, captured on an accepted start
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when diff/borrow_out take a new result
//   diff       : (A - B) mod 2^WIDTH, held until the next operation completes
//   borrow_out : 1 iff A < B (unsigned), held with diff
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CNT_W = clog2(WIDTH);

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic               brw_q,    brw_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   diff_q,   diff_d;
  logic               borrow_q, borrow_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;

  logic cell_d_c;
  logic cell_bout_c;
  logic last_bit_c;

  // The single shared arithmetic cell.
  serial_sub_ctrl_fs_cell u_fs_cell (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .bin    (brw_q),
    .d_c    (cell_d_c),
    .bout_c (cell_bout_c)
  );

  assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    case (state_q)
      // DONE accepts start exactly like IDLE so operations can run back to back.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // Result enters at the MSB so bit 0 ends up at position 0 after WIDTH shifts.
        res_sh_d = {cell_d_c, res_sh_q[WIDTH-1:1]};
        brw_d    = cell_bout_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit_c) begin
          diff_d   = res_sh_d;
          borrow_d = cell_bout_c;
          state_d  = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they align with it.
  assign busy_d = (state_d == ST_SHIFT);
  assign done_d = (state_d == ST_DONE);

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: an 8-bit instance for protocol, hold,
// back-to-back and reset behaviour, and a 4-bit instance swept over all pairs.
module tb_serial_sub_ctrl;

  logic       clk;
  logic       rst;

  logic       st8;
  logic [7:0] a8, b8;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;

  logic       st4;
  logic [3:0] a4, b4;
  logic       busy4, done4, borrow4;
  logic [3:0] diff4;

  int errors;
  int checks;

  logic [7:0] hold_d;
  logic       hold_b;

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .start      (st8),
    .a_in       (a8),
    .b_in       (b8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (borrow8)
  );

  serial_sub_ctrl #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .start      (st4),
    .a_in       (a4),
    .b_in       (b4),
    .busy       (busy4),
    .done       (done4),
    .diff       (diff4),
    .borrow_out (borrow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Eight SHIFT-cycle samples: busy high, no done, previous result held.
  task automatic shift_phase8();
    for (int i = 0; i < 8; i++) begin
      chk("busy8", 32'(busy8), 32'd1);
      chk("no_early_done8", 32'(done8), 32'd0);
      chk("hold_diff8", 32'(diff8), 32'(hold_d));
      chk("hold_borrow8", 32'(borrow8), 32'(hold_b));
      @(posedge clk); #1;
    end
  endtask

  task automatic done_phase8(input logic [7:0] ed, input logic eb);
    chk("done8", 32'(done8), 32'd1);
    chk("busy_off8", 32'(busy8), 32'd0);
    chk("diff8", 32'(diff8), 32'(ed));
    chk("borrow8", 32'(borrow8), 32'(eb));
    hold_d = ed;
    hold_b = eb;
  endtask

  // Single operation; called and returns #1 after a rising edge.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic eb);
    a8 = a; b8 = b; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    shift_phase8();
    done_phase8(ed, eb);
    @(posedge clk); #1;
    chk("done_pulse8", 32'(done8), 32'd0);
    chk("idle8", 32'(busy8), 32'd0);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b);
    int         ndone;
    logic       slot_ok;
    logic [3:0] got_d;
    logic       got_b;
    logic [3:0] exp_d;
    ndone = 0; slot_ok = 1'b1; got_d = 4'hx; got_b = 1'bx;
    exp_d = a - b;
    a4 = a; b4 = b; st4 = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      if (done4 === 1'b1) begin
        ndone++;
        if (j != 4) slot_ok = 1'b0;
        got_d = diff4;
        got_b = borrow4;
      end
    end
    chk("done_once4", 32'(ndone), 32'd1);
    chk("done_slot4", 32'(slot_ok), 32'd1);
    chk("diff4", 32'(got_d), 32'(exp_d));
    chk("borrow4", 32'(got_b), 32'(a < b));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    hold_d = 8'h00;
    hold_b = 1'b0;
    a4 = '0; b4 = '0; st4 = 1'b0;

    // Reset with a coincident start: reset wins.
    rst = 1'b1;
    a8 = 8'h5A; b8 = 8'h23; st8 = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_diff8", 32'(diff8), 32'd0);
    chk("rst_borrow8", 32'(borrow8), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_diff4", 32'(diff4), 32'd0);
    st8 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle8", 32'(busy8), 32'd0);

    // Basic operations.
    run8(8'h5A, 8'h23, 8'h37, 1'b0);
    run8(8'h10, 8'h20, 8'hF0, 1'b1);
    run8(8'h00, 8'h01, 8'hFF, 1'b1);
    run8(8'hFF, 8'hFF, 8'h00, 1'b0);

    // Result hold across a following operation.
    run8(8'h5A, 8'h23, 8'h37, 1'b0);
    run8(8'h00, 8'h01, 8'hFF, 1'b1);

    // Start held high; a_in changes mid-operation; back-to-back restart from DONE.
    a8 = 8'h05; b8 = 8'h03; st8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'hAA;
    shift_phase8();
    done_phase8(8'h02, 1'b0);
    @(posedge clk); #1;
    st8 = 1'b0;
    shift_phase8();
    done_phase8(8'hA7, 1'b0);
    @(posedge clk); #1;
    chk("b2b_done_pulse8", 32'(done8), 32'd0);
    chk("b2b_idle8", 32'(busy8), 32'd0);

    // Asynchronous reset after four SHIFT cycles.
    a8 = 8'h80; b8 = 8'h01; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy8", 32'(busy8), 32'd0);
    chk("arst_done8", 32'(done8), 32'd0);
    chk("arst_diff8", 32'(diff8), 32'd0);
    chk("arst_borrow8", 32'(borrow8), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    hold_d = 8'h00;
    hold_b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("arst_no_done8", 32'(done8), 32'd0);
      chk("arst_no_busy8", 32'(busy8), 32'd0);
      @(posedge clk); #1;
    end
    run8(8'h80, 8'h01, 8'h7F, 1'b0);

    // Exhaustive 4-bit sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run4(4'(a), 4'(b));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
